// File: rtl/execute.sv
// Execute stage: single-cycle ALU for RV32I register/immediate/address/LUI ops,
// plus a 32-cycle iterative shift-add multiplier for MUL that stalls decode via busy.
module execute (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_in1,
  input  logic [31:0] alu_in2,
  input  logic [31:0] ins_ex_in,
  input  logic        in_valid,
  output logic        busy,
  output logic [31:0] alu_out,
  output logic [4:0]  alu_rd,
  output logic        alu_reg_w_en,
  output logic [31:0] ins_ex_out
);

  typedef enum logic {StIdle, StMul} state_e;

  localparam logic [6:0] OpReg  = 7'b0110011;
  localparam logic [6:0] OpImm  = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpStor = 7'b0100011;
  localparam logic [6:0] OpLui  = 7'b0110111;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] acc_q, mcand_q, mplier_q;
  logic [4:0]  mul_rd_q;
  logic [31:0] alu_out_q, ins_ex_out_q;
  logic [4:0]  alu_rd_q;
  logic        w_en_q;

  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, sh;
  logic        accept, mul_last;
  logic [31:0] res, acc_next;
  logic        upd, wr, mul_start;

  assign op       = ins_ex_in[6:0];
  assign rd       = ins_ex_in[11:7];
  assign f3       = ins_ex_in[14:12];
  assign f7       = ins_ex_in[31:25];
  assign sh       = alu_in2[4:0];
  assign busy     = (state_q == StMul);
  assign accept   = in_valid && !busy;
  assign mul_last = (cnt_q == 5'd31);
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

  assign alu_out      = alu_out_q;
  assign alu_rd       = alu_rd_q;
  assign alu_reg_w_en = w_en_q;
  assign ins_ex_out   = ins_ex_out_q;

  // Decode: upd = result/rd get registered, wr = result is a register write.
  always_comb begin
    res       = 32'd0;
    upd       = 1'b0;
    wr        = 1'b0;
    mul_start = 1'b0;
    case (op)
      OpReg: begin
        if (f7 == 7'b0000000) begin
          upd = 1'b1;
          wr  = 1'b1;
          case (f3)
            3'b000:  res = alu_in1 + alu_in2;
            3'b001:  res = alu_in1 << sh;
            3'b010:  res = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
            3'b011:  res = {31'd0, alu_in1 < alu_in2};
            3'b100:  res = alu_in1 ^ alu_in2;
            3'b101:  res = alu_in1 >> sh;
            3'b110:  res = alu_in1 | alu_in2;
            default: res = alu_in1 & alu_in2;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          res = alu_in1 - alu_in2;
          upd = 1'b1;
          wr  = 1'b1;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          res = $signed(alu_in1) >>> sh;
          upd = 1'b1;
          wr  = 1'b1;
        end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
          mul_start = 1'b1;
        end
      end
      OpImm: begin
        upd = 1'b1;
        wr  = 1'b1;
        case (f3)
          3'b000: res = alu_in1 + alu_in2;
          3'b010: res = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
          3'b011: res = {31'd0, alu_in1 < alu_in2};
          3'b100: res = alu_in1 ^ alu_in2;
          3'b110: res = alu_in1 | alu_in2;
          3'b111: res = alu_in1 & alu_in2;
          3'b001: begin
            res = alu_in1 << sh;
            upd = (f7 == 7'b0000000);
            wr  = upd;
          end
          default: begin
            if (f7 == 7'b0000000) begin
              res = alu_in1 >> sh;
            end else if (f7 == 7'b0100000) begin
              res = $signed(alu_in1) >>> sh;
            end else begin
              upd = 1'b0;
              wr  = 1'b0;
            end
          end
        endcase
      end
      OpLoad, OpStor: begin
        res = alu_in1 + alu_in2;
        upd = 1'b1;
      end
      OpLui: begin
        res = alu_in2;
        upd = 1'b1;
        wr  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept && mul_start) state_d = StMul;
      StMul:   if (mul_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= 5'd0;
      acc_q        <= 32'd0;
      mcand_q      <= 32'd0;
      mplier_q     <= 32'd0;
      mul_rd_q     <= 5'd0;
      alu_out_q    <= 32'd0;
      alu_rd_q     <= 5'd0;
      w_en_q       <= 1'b0;
      ins_ex_out_q <= 32'd0;
    end else begin
      w_en_q <= 1'b0;
      if (state_q == StMul) begin
        // Multiplicand shifts left and multiplier right, so bit i lines up each cycle.
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 5'd1;
        if (mul_last) begin
          alu_out_q <= acc_next;
          alu_rd_q  <= mul_rd_q;
          w_en_q    <= (mul_rd_q != 5'd0);
        end
      end else if (accept) begin
        ins_ex_out_q <= ins_ex_in;
        if (upd) begin
          alu_out_q <= res;
          alu_rd_q  <= rd;
          w_en_q    <= wr && (rd != 5'd0);
        end
        if (mul_start) begin
          mcand_q  <= alu_in1;
          mplier_q <= alu_in2;
          acc_q    <= 32'd0;
          cnt_q    <= 5'd0;
          mul_rd_q <= rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute.sv
// Bench for execute: directed literal checks plus randomized traffic compared every
// cycle against a behavioural model of the stage's visible outputs.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_in1, alu_in2, ins_ex_in;
  logic        in_valid;
  logic        busy;
  logic [31:0] alu_out;
  logic [4:0]  alu_rd;
  logic        alu_reg_w_en;
  logic [31:0] ins_ex_out;

  execute dut (
    .clk          (clk),
    .rst          (rst),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .ins_ex_in    (ins_ex_in),
    .in_valid     (in_valid),
    .busy         (busy),
    .alu_out      (alu_out),
    .alu_rd       (alu_rd),
    .alu_reg_w_en (alu_reg_w_en),
    .ins_ex_out   (ins_ex_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: what the outputs must show after the next edge.
  logic [31:0] exp_out, exp_ins, mul_prod;
  logic [4:0]  exp_rd, mul_rd;
  logic        exp_wen, exp_busy;
  int          mul_left;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    logic [9:0] mid;
    mid = 10'($urandom);
    return {f7, mid, f3, rd, op};
  endfunction

  // kind: 0 bubble, 1 register write, 2 address only, 3 multiply
  function automatic void ref_exec(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, output int kind,
                                   output logic [31:0] r);
    logic [6:0] op, f7;
    logic [2:0] f3;
    int sh;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; sh = int'(b % 32);
    kind = 0; r = 0;
    if (op == 7'h33 && f7 == 7'h00) begin
      kind = 1;
      if (f3 == 0) r = a + b;
      if (f3 == 1) r = a << sh;
      if (f3 == 2) r = (int'(a) < int'(b)) ? 1 : 0;
      if (f3 == 3) r = (a < b) ? 1 : 0;
      if (f3 == 4) r = a ^ b;
      if (f3 == 5) r = a >> sh;
      if (f3 == 6) r = a | b;
      if (f3 == 7) r = a & b;
    end else if (op == 7'h33 && f7 == 7'h20 && f3 == 0) begin
      kind = 1; r = a - b;
    end else if (op == 7'h33 && f7 == 7'h20 && f3 == 5) begin
      kind = 1; r = 32'(int'(a) >>> sh);
    end else if (op == 7'h33 && f7 == 7'h01 && f3 == 0) begin
      kind = 3; r = a * b;
    end else if (op == 7'h13) begin
      kind = 1;
      if (f3 == 0) r = a + b;
      if (f3 == 2) r = (int'(a) < int'(b)) ? 1 : 0;
      if (f3 == 3) r = (a < b) ? 1 : 0;
      if (f3 == 4) r = a ^ b;
      if (f3 == 6) r = a | b;
      if (f3 == 7) r = a & b;
      if (f3 == 1) begin
        if (f7 == 7'h00) r = a << sh; else kind = 0;
      end
      if (f3 == 5) begin
        if (f7 == 7'h00) r = a >> sh;
        else if (f7 == 7'h20) r = 32'(int'(a) >>> sh);
        else kind = 0;
      end
    end else if (op == 7'h03 || op == 7'h23) begin
      kind = 2; r = a + b;
    end else if (op == 7'h37) begin
      kind = 1; r = b;
    end
  endfunction

  task automatic model_reset();
    exp_out = 0; exp_ins = 0; exp_rd = 0; exp_wen = 0; exp_busy = 0;
    mul_left = 0; mul_prod = 0; mul_rd = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] ins, input logic [31:0] a,
                            input logic [31:0] b);
    int kind;
    logic [31:0] r;
    exp_wen = 0;
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        exp_out = mul_prod; exp_rd = mul_rd; exp_wen = (mul_rd != 0);
      end
    end else if (v) begin
      exp_ins = ins;
      ref_exec(ins, a, b, kind, r);
      if (kind == 1 || kind == 2) begin
        exp_out = r; exp_rd = ins[11:7];
        exp_wen = (kind == 1) && (ins[11:7] != 0);
      end else if (kind == 3) begin
        mul_left = 32; mul_prod = r; mul_rd = ins[11:7];
      end
    end
    exp_busy = (mul_left > 0);
  endtask

  // Drive one cycle's inputs mid-low-phase and advance the model to the next edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk); #1;
    in_valid = v; ins_ex_in = ins; alu_in1 = a; alu_in2 = b;
    model_step(v, ins, a, b);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      n_tests++;
      if (busy !== exp_busy || alu_out !== exp_out || alu_rd !== exp_rd ||
          alu_reg_w_en !== exp_wen || ins_ex_out !== exp_ins) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got busy=%b out=%h rd=%0d wen=%b ins=%h expected busy=%b out=%h rd=%0d wen=%b ins=%h",
                 $time, busy, alu_out, alu_rd, alu_reg_w_en, ins_ex_out,
                 exp_busy, exp_out, exp_rd, exp_wen, exp_ins);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [4:0] rd;
    logic [2:0] f3;
    rd = 5'($urandom); f3 = 3'($urandom);
    case ($urandom_range(0, 12))
      0, 1: return enc(7'h00, f3, rd, 7'h33);
      2:    return enc(7'h20, ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd0, rd, 7'h33);
      3:    return enc(7'h20, f3, rd, 7'h33);
      4:    return ($urandom_range(0, 5) == 0) ? enc(7'h01, 3'd0, rd, 7'h33)
                                               : enc(7'h01, f3, rd, 7'h33);
      5, 6: return enc(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, f3, rd, 7'h13);
      7:    return enc(7'($urandom), f3, rd, 7'h13);
      8:    return enc(7'($urandom), f3, rd, 7'h03);
      9:    return enc(7'($urandom), f3, rd, 7'h23);
      10:   return enc(7'($urandom), f3, rd, 7'h37);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] mul_ins, got;
    int busy_cnt, res_edge;
    rst = 1'b1; in_valid = 0; ins_ex_in = 0; alu_in1 = 0; alu_in2 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_alu_out", alu_out, 32'h0);
    check("reset_alu_rd", {27'd0, alu_rd}, 32'h0);
    check("reset_wen", {31'd0, alu_reg_w_en}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    check("reset_ins_out", ins_ex_out, 32'h0);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Signed overflow wraps.
    step(1, enc(7'h00, 3'd0, 5'd3, 7'h33), 32'h7FFF_FFFF, 32'h1); settle();
    check("add_ovf_out", alu_out, 32'h8000_0000);
    check("add_ovf_rd", {27'd0, alu_rd}, 32'd3);
    check("add_ovf_wen", {31'd0, alu_reg_w_en}, 32'd1);
    step(0, 32'h0, 32'h0, 32'h0); settle();
    check("add_wen_one_cycle", {31'd0, alu_reg_w_en}, 32'd0);
    check("add_out_hold", alu_out, 32'h8000_0000);

    step(1, enc(7'h20, 3'd5, 5'd4, 7'h33), 32'h8000_0000, 32'd4); settle();
    check("sra", alu_out, 32'hF800_0000);
    step(1, enc(7'h00, 3'd5, 5'd4, 7'h33), 32'h8000_0000, 32'd4); settle();
    check("srl", alu_out, 32'h0800_0000);
    step(1, enc(7'h00, 3'd2, 5'd4, 7'h33), 32'hFFFF_FFFF, 32'd1); settle();
    check("slt", alu_out, 32'd1);
    step(1, enc(7'h00, 3'd3, 5'd4, 7'h33), 32'hFFFF_FFFF, 32'd1); settle();
    check("sltu", alu_out, 32'd0);

    // Multiply with in_valid pulses while busy.
    mul_ins = enc(7'h01, 3'd0, 5'd5, 7'h33);
    step(1, mul_ins, 32'hFFFF_FFFF, 32'd3); settle();
    busy_cnt = busy ? 1 : 0;
    res_edge = 0;
    got = 32'h0;
    for (int k = 0; k < 40; k++) begin
      step(k % 2 == 0, enc(7'h00, 3'd0, 5'd9, 7'h33), 32'd1, 32'd1); settle();
      if (busy) busy_cnt++;
      if (alu_reg_w_en) begin
        res_edge = k + 2;
        got = alu_out;
        break;
      end
    end
    check("mul_result", got, 32'hFFFF_FFFD);
    check("mul_rd", {27'd0, alu_rd}, 32'd5);
    check("mul_busy_cycles", busy_cnt, 32'd32);
    check("mul_result_edge", res_edge, 32'd33);
    check("mul_ins_out", ins_ex_out, mul_ins);

    step(1, enc(7'h00, 3'd2, 5'd8, 7'h23), 32'h100, 32'h8); settle();
    check("store_addr", alu_out, 32'h108);
    check("store_wen", {31'd0, alu_reg_w_en}, 32'd0);
    step(1, enc(7'h00, 3'd0, 5'd7, 7'h37), 32'hDEAD_BEEF, 32'h1234_5000); settle();
    check("lui_out", alu_out, 32'h1234_5000);
    check("lui_wen", {31'd0, alu_reg_w_en}, 32'd1);

    step(1, enc(7'h00, 3'd0, 5'd0, 7'h13), 32'd0, 32'd5); settle();
    check("addi_x0_out", alu_out, 32'd5);
    check("addi_x0_wen", {31'd0, alu_reg_w_en}, 32'd0);
    step(1, 32'h0000_007F, 32'd9, 32'd9); settle();
    check("unknown_hold", alu_out, 32'd5);
    check("unknown_wen", {31'd0, alu_reg_w_en}, 32'd0);
    check("unknown_ins_out", ins_ex_out, 32'h0000_007F);

    // Reset between edges, 10 cycles into a multiply.
    step(1, enc(7'h01, 3'd0, 5'd6, 7'h33), 32'd5, 32'd7);
    repeat (10) step(0, 32'h0, 32'h0, 32'h0);
    @(negedge clk); #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_out", alu_out, 32'h0);
    check("rst_mid_rd", {27'd0, alu_rd}, 32'h0);
    check("rst_mid_wen", {31'd0, alu_reg_w_en}, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'h0);
    check("rst_mid_ins", ins_ex_out, 32'h0);
    @(negedge clk); #1 rst = 1'b0;
    step(1, enc(7'h00, 3'd0, 5'd8, 7'h33), 32'd2, 32'd3); settle();
    check("add_after_rst", alu_out, 32'd5);
    check("add_after_rst_wen", {31'd0, alu_reg_w_en}, 32'd1);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_ins(), rand_operand(), rand_operand());
    end
    repeat (40) step(0, 32'h0, 32'h0, 32'h0);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on posedge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: alu_in1  in  32  operand 1 (forwarded rs1 value) from decode.
REQ-004 SHALL have: alu_in2  in  32  operand 2 (rs2 value or sign-extended/shifted immediate) from decode.
REQ-005 SHALL have: ins_ex_in  in  32  instruction word from decode.
REQ-006 SHALL have: in_valid  in  1  operands/instruction valid this cycle.
REQ-007 SHALL have: busy  out  1  stall request to upstream; combinational, high while in MUL state.
REQ-008 SHALL have: alu_out  out  32  registered result, fed back to decode for forwarding.
REQ-009 SHALL have: alu_rd  out  5  destination register of the last completed instruction.
REQ-010 SHALL have: alu_reg_w_en  out  1  one-cycle pulse: alu_out valid for writeback/forwarding.
REQ-011 SHALL have: ins_ex_out  out  32  registered copy of last accepted instruction, for the downstream stage.

Function
REQ-012 SHALL accept an instruction at a posedge only when in_valid=1 and busy=0; otherwise inputs are ignored.
REQ-013 SHALL decode op=ins[6:0], rd=ins[11:7], f3=ins[14:12], f7=ins[31:25].
REQ-014 SHALL implement FSM states IDLE and MUL; reset state IDLE.
REQ-015 Single-cycle ops: result, alu_rd, ins_ex_out registered at the accepting edge (latency 1); FSM stays IDLE.
REQ-016 op 0110011, f7=0000000/0100000: ADD/SUB (f7[5]=1 -> SUB), SLL, SLT, SLTU, XOR, SRL/SRA (f7[5]=1 -> SRA), OR, AND per f3; shift amount = alu_in2[4:0].
REQ-017 op 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI (ins[30] selects SRAI); shift amount = alu_in2[4:0].
REQ-018 op 0000011 (load) and 0100011 (store): alu_out = alu_in1 + alu_in2 (address); alu_reg_w_en = 0.
REQ-019 op 0110111 (LUI): alu_out = alu_in2; alu_reg_w_en = 1.
REQ-020 op 0110011, f7=0000001, f3=000 (MUL): on accept enter MUL, latch operands, clear accumulator and 5-bit counter; busy=1 from the cycle after accept.
REQ-021 MUL state: one shift-add iteration per cycle over multiplier bits 0..31; on the 32nd iteration edge write low 32 bits of product to alu_out, pulse alu_reg_w_en, return to IDLE (accept-to-result latency 33 edges, busy high exactly 32 cycles).
REQ-022 MUL latency SHALL be fixed regardless of operand values; result modulo 2^32 (signed and unsigned low halves identical).
REQ-023 Any other opcode or f3/f7 combination: treated as bubble, alu_reg_w_en = 0, alu_out/alu_rd hold.
REQ-024 alu_reg_w_en SHALL be forced 0 when rd = 0.
REQ-025 alu_reg_w_en SHALL be high for exactly one cycle per writing instruction; deasserts at the next edge when no writing instruction completes.
REQ-026 alu_out and alu_rd SHALL hold their last value between completions; ins_ex_out updates only on accept.
REQ-027 Arithmetic 32-bit, wrap-around on overflow; SLT/SLTI signed, SLTU/SLTIU unsigned, result 0 or 1.

Reset
REQ-028 rst=1 SHALL immediately (without clk) force state IDLE, busy=0, alu_out=0, alu_rd=0, alu_reg_w_en=0, ins_ex_out=0, counter and accumulator 0.
REQ-029 rst asserted mid-MUL SHALL abort the multiply; no alu_reg_w_en pulse is produced for it.
REQ-030 After rst deasserts, first instruction SHALL be accepted at the first posedge with in_valid=1.

Verification
REQ-031 ADD x3: alu_in1=0x7FFFFFFF, alu_in2=1, rd=3 -> next edge alu_out=0x80000000, alu_rd=3, alu_reg_w_en=1 for one cycle.
REQ-032 SRA vs SRL: alu_in1=0x80000000, alu_in2=4 -> SRA gives 0xF8000000, SRL gives 0x08000000; SLT(-1,1)=1, SLTU(0xFFFFFFFF,1)=0.
REQ-033 MUL x5: 0xFFFFFFFF x 3 -> busy high 32 cycles, in_valid pulses during busy ignored, alu_out=0xFFFFFFFD with w_en pulse at 33rd edge after accept.
REQ-034 Store then LUI back-to-back: store addr 0x100+0x8 -> alu_out=0x108, w_en=0; LUI alu_in2=0x12345000, rd=7 -> alu_out=0x12345000, w_en=1.
REQ-035 rd=0 ADDI 5 -> alu_out=5, alu_reg_w_en=0; unknown opcode 0x7F -> outputs hold, w_en=0.
REQ-036 rst asserted 10 cycles into MUL, between clock edges -> all outputs 0 immediately, no w_en pulse; next ADD after release completes normally.
